// File: rtl/pagerank_pkg.sv
// -----------------------------------------------------------------------------
// pagerank_pkg
// Shared definitions for the pagerank fetch blocks:
//   - DEF_FULL_WIDTH / DEF_WIDTH : default memory line width and element width
//   - fetch_state_e              : range fetcher FSM state encoding
//   - window_bounds()            : exclusive end slot of the valid window in a line
// -----------------------------------------------------------------------------
package pagerank_pkg;

  localparam int DEF_FULL_WIDTH = 512;
  localparam int DEF_WIDTH      = 64;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    DELIVER = 3'd3,
    DONE    = 3'd4
  } fetch_state_e;

  // min(elems, base + remaining), evaluated so that a large remaining count
  // cannot wrap the 16-bit sum.
  function automatic logic [15:0] window_bounds(input logic [15:0] base,
                                                input logic [15:0] remaining,
                                                input logic [15:0] elems);
    logic [15:0] room_s;
    room_s = elems - base;
    if (remaining >= room_s) begin
      window_bounds = elems;
    end else begin
      window_bounds = base + remaining;
    end
  endfunction

endpackage

// File: rtl/range_fetcher.sv
// -----------------------------------------------------------------------------
// range_fetcher
// Fetches the memory lines covering an element range [req_start, req_start+req_count)
// one line at a time and hands each line to the read buffer together with the
// window of valid element slots [out_base, out_bounds).
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   req_valid/req_ready     range request handshake (ready only while idle)
//   req_start, req_count    first element index, number of elements
//   mem_ar*                 line read request (one outstanding at most)
//   mem_rvalid, mem_rdata   line read response
//   out_valid/out_ready     line + window handshake towards the read buffer
//   out_data/base/bounds    held line and its valid slot window
//   done                    one-cycle completion pulse
//   stat_lines, stat_stall  statistics (live only with RANGE_FETCHER_STATS_EN)
//
// Build option: define RANGE_FETCHER_STATS_EN to enable the statistics
// counters; otherwise both stat ports read as zero.
// -----------------------------------------------------------------------------
module range_fetcher
  import pagerank_pkg::*;
#(
  parameter int FULL_WIDTH = DEF_FULL_WIDTH,
  parameter int WIDTH      = DEF_WIDTH,
  parameter int ADDR_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_start,
  input  logic [15:0]           req_count,
  output logic                  mem_arvalid,
  input  logic                  mem_arready,
  output logic [ADDR_W-1:0]     mem_araddr,
  input  logic                  mem_rvalid,
  input  logic [FULL_WIDTH-1:0] mem_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [FULL_WIDTH-1:0] out_data,
  output logic [7:0]            out_base,
  output logic [7:0]            out_bounds,
  output logic                  done,
  output logic [31:0]           stat_lines,
  output logic [31:0]           stat_stall
);

  localparam int          E      = FULL_WIDTH / WIDTH;
  localparam int          BYTES  = FULL_WIDTH / 8;
  localparam int          OFF_W  = $clog2(BYTES);
  localparam int          LINE_W = ADDR_W - OFF_W;
  localparam logic [15:0] E16    = 16'(E);

  fetch_state_e      state_r;
  logic [LINE_W-1:0] line_r;
  logic [15:0]       base_r;
  logic [15:0]       rem_r;
  logic [15:0]       bounds_s;
  logic [15:0]       taken_s;
  logic [15:0]       rem_next_s;

  // Line index occupies the address bits above the line offset, so the line
  // counter wraps naturally with the address space.
  assign mem_araddr = {line_r, {OFF_W{1'b0}}};

  // Window of the current line and the count left after delivering it.
  always_comb begin
    bounds_s   = window_bounds(base_r, rem_r, E16);
    taken_s    = bounds_s - base_r;
    rem_next_s = rem_r - taken_s;
  end

  // Request sequencing: one line read at a time, each returned line is held
  // with its window until the read buffer takes it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      line_r      <= '0;
      base_r      <= 16'd0;
      rem_r       <= 16'd0;
      req_ready   <= 1'b1;
      mem_arvalid <= 1'b0;
      out_valid   <= 1'b0;
      done        <= 1'b0;
      out_data    <= '0;
      out_base    <= 8'd0;
      out_bounds  <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            if (req_count != 16'd0) begin
              line_r      <= LINE_W'(req_start / 32'(E));
              base_r      <= 16'(req_start % 32'(E));
              rem_r       <= req_count;
              mem_arvalid <= 1'b1;
              state_r     <= ISSUE;
            end else begin
              // Empty range: complete without touching memory.
              done    <= 1'b1;
              state_r <= DONE;
            end
          end
        end
        ISSUE: begin
          if (mem_arready) begin
            mem_arvalid <= 1'b0;
            state_r     <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            out_data   <= mem_rdata;
            out_base   <= base_r[7:0];
            out_bounds <= bounds_s[7:0];
            out_valid  <= 1'b1;
            state_r    <= DELIVER;
          end
        end
        DELIVER: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            rem_r     <= rem_next_s;
            base_r    <= 16'd0;
            line_r    <= line_r + LINE_W'(1);
            if (rem_next_s != 16'd0) begin
              mem_arvalid <= 1'b1;
              state_r     <= ISSUE;
            end else begin
              done    <= 1'b1;
              state_r <= DONE;
            end
          end
        end
        DONE: begin
          done      <= 1'b0;
          req_ready <= 1'b1;
          state_r   <= IDLE;
        end
        default: begin
          state_r     <= IDLE;
          req_ready   <= 1'b1;
          mem_arvalid <= 1'b0;
          out_valid   <= 1'b0;
          done        <= 1'b0;
        end
      endcase
    end
  end

`ifdef RANGE_FETCHER_STATS_EN
  logic [31:0] stat_lines_r;
  logic [31:0] stat_stall_r;

  // Saturating counters: lines captured and cycles the read buffer held us off.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_lines_r <= 32'd0;
      stat_stall_r <= 32'd0;
    end else begin
      if ((state_r == WAIT) && mem_rvalid && (stat_lines_r != 32'hFFFF_FFFF)) begin
        stat_lines_r <= stat_lines_r + 32'd1;
      end
      if (out_valid && !out_ready && (stat_stall_r != 32'hFFFF_FFFF)) begin
        stat_stall_r <= stat_stall_r + 32'd1;
      end
    end
  end

  assign stat_lines = stat_lines_r;
  assign stat_stall = stat_stall_r;
`else
  assign stat_lines = 32'd0;
  assign stat_stall = 32'd0;
`endif

endmodule

// File: tb/tb_range_fetcher.sv
// -----------------------------------------------------------------------------
// tb_range_fetcher
// Self-checking bench for range_fetcher. A memory/read-buffer driver records
// every accepted read address and every delivered window; each test compares
// those records with the line/window list computed arithmetically from the
// requested element range.
// -----------------------------------------------------------------------------
module tb_range_fetcher;

`ifdef RANGE_FETCHER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam int E = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [31:0]  req_start;
  logic [15:0]  req_count;
  logic         mem_arvalid;
  logic         mem_arready;
  logic [31:0]  mem_araddr;
  logic         mem_rvalid;
  logic [511:0] mem_rdata;
  logic         out_valid;
  logic         out_ready;
  logic [511:0] out_data;
  logic [7:0]   out_base;
  logic [7:0]   out_bounds;
  logic         done;
  logic [31:0]  stat_lines;
  logic [31:0]  stat_stall;

  int n_cmp = 0;
  int n_bad = 0;

  // Observations from the driver
  logic [31:0]  obs_addr[$];
  int           obs_base[$];
  int           obs_bnd[$];
  logic [511:0] obs_data[$];
  int           done_cnt;
  int           stab_bad;
  bit           timed_out;
  logic         done_after;
  logic         rdy_after;

  // Reference expectations
  logic [31:0]  exp_addr[$];
  int           exp_base[$];
  int           exp_bnd[$];

  range_fetcher dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_start(req_start), .req_count(req_count),
    .mem_arvalid(mem_arvalid), .mem_arready(mem_arready), .mem_araddr(mem_araddr),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_base(out_base), .out_bounds(out_bounds),
    .done(done), .stat_lines(stat_lines), .stat_stall(stat_stall)
  );

  always #5 clk = ~clk;

  function automatic logic [511:0] line_data(input logic [31:0] a);
    logic [31:0] w;
    w = a ^ 32'h5A5A_C3C3;
    line_data = {w, ~w, w + 32'd1, w ^ 32'hFFFF_0000, {12{w}}};
  endfunction

  // Lines touched by [s, s+c) and the slot window inside each one.
  task automatic build_model(input logic [31:0] s, input logic [15:0] c);
    longint first, last, lo, hi, st, en;
    exp_addr.delete(); exp_base.delete(); exp_bnd.delete();
    if (c != 16'd0) begin
      st = longint'(s);
      en = st + longint'(c);
      first = st / E;
      last  = (en - 1) / E;
      for (longint l = first; l <= last; l++) begin
        lo = (st > l * E) ? st : l * E;
        hi = (en < (l + 1) * E) ? en : (l + 1) * E;
        exp_addr.push_back(32'((l * 64) % 64'h1_0000_0000));
        exp_base.push_back(int'(lo - l * E));
        exp_bnd.push_back(int'(hi - l * E));
      end
    end
  endtask

  // Drives one request to completion and records what the DUT produced.
  task automatic do_request(input logic [31:0] s, input logic [15:0] c,
                            input int ar_delay, input int r_delay,
                            input int stall, input bit stray);
    int arw, rw, sw, cyc;
    bit busy, rpend;
    logic [31:0]  ar_first;
    logic [511:0] f_data;
    logic [7:0]   f_base, f_bnd;
    obs_addr.delete(); obs_base.delete(); obs_bnd.delete(); obs_data.delete();
    done_cnt = 0; stab_bad = 0; timed_out = 1'b0;
    arw = 0; rw = 0; sw = 0; cyc = 0; rpend = 1'b0; busy = 1'b1;
    ar_first = 32'd0; f_data = '0; f_base = 8'd0; f_bnd = 8'd0;
    @(negedge clk);
    req_valid = 1'b1; req_start = s; req_count = c;
    @(negedge clk);
    req_valid = 1'b0;
    while (busy) begin
      mem_arready = 1'b0; mem_rvalid = 1'b0; out_ready = 1'b0;
      if (done) begin
        done_cnt++;
        busy = 1'b0;
      end
      if (mem_arvalid) begin
        if (arw == 0) ar_first = mem_araddr;
        else if (mem_araddr !== ar_first) stab_bad++;
        if (arw < ar_delay) arw++;
        else begin
          mem_arready = 1'b1;
          obs_addr.push_back(mem_araddr);
          arw = 0; rpend = 1'b1; rw = 0;
        end
      end else if (rpend) begin
        if (rw < r_delay) rw++;
        else begin
          mem_rvalid = 1'b1;
          mem_rdata  = line_data(obs_addr[obs_addr.size()-1]);
          rpend = 1'b0;
        end
      end else if (stray && ($urandom_range(0, 3) == 0)) begin
        mem_rvalid = 1'b1;
        mem_rdata  = {16{$urandom()}};
      end
      if (out_valid) begin
        if (sw == 0) begin
          f_data = out_data; f_base = out_base; f_bnd = out_bounds;
        end else if (out_data !== f_data || out_base !== f_base || out_bounds !== f_bnd) begin
          stab_bad++;
        end
        if (sw < stall) sw++;
        else begin
          out_ready = 1'b1;
          obs_base.push_back(int'(out_base));
          obs_bnd.push_back(int'(out_bounds));
          obs_data.push_back(out_data);
          sw = 0;
        end
      end
      @(negedge clk);
      cyc++;
      if (busy && cyc > 3000) begin
        timed_out = 1'b1;
        busy = 1'b0;
      end
    end
    mem_arready = 1'b0; mem_rvalid = 1'b0; out_ready = 1'b0;
    done_after = done;
    rdy_after  = req_ready;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({req_ready, mem_arvalid, out_valid, done} !== 4'b1000 || out_base !== 8'd0 ||
        out_bounds !== 8'd0 || out_data !== 512'd0 || stat_lines !== 32'd0 || stat_stall !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_state: got rdy=%b arv=%b ov=%b done=%b base=%0d bnd=%0d lines=%0d stall=%0d, want rdy=1 others 0",
               req_ready, mem_arvalid, out_valid, done, out_base, out_bounds, stat_lines, stat_stall);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_line();
    do_request(32'd3, 16'd4, 0, 1, 0, 1'b0);
    n_cmp++;
    if (obs_addr.size() != 1 || obs_addr[0] !== 32'h0) begin
      n_bad++; $display("FAIL single_read: got %0d reads, want 1 read at 0x0", obs_addr.size());
    end
    n_cmp++;
    if (obs_base.size() != 1 || obs_base[0] != 3 || obs_bnd[0] != 7) begin
      n_bad++; $display("FAIL single_window: got %0d windows, want one (3,7)", obs_base.size());
    end
    n_cmp++;
    if (done_cnt != 1 || done_after !== 1'b0 || rdy_after !== 1'b1 || timed_out) begin
      n_bad++; $display("FAIL single_done: got done=%0d after=%b rdy=%b to=%b, want 1,0,1,0",
                        done_cnt, done_after, rdy_after, timed_out);
    end
  endtask

  task automatic test_multi_line();
    logic [31:0] l0;
    l0 = stat_lines;
    build_model(32'd6, 16'd12);
    do_request(32'd6, 16'd12, 1, 2, 0, 1'b1);
    n_cmp++;
    if (obs_addr.size() != 3 || obs_base.size() != 3 || done_cnt != 1 || timed_out) begin
      n_bad++; $display("FAIL multi_count: got %0d reads %0d windows done=%0d, want 3 3 1",
                        obs_addr.size(), obs_base.size(), done_cnt);
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (obs_addr[i] !== exp_addr[i] || obs_base[i] != exp_base[i] || obs_bnd[i] != exp_bnd[i] ||
            obs_data[i] !== line_data(exp_addr[i])) begin
          n_bad++; $display("FAIL multi_line%0d: got addr=%h (%0d,%0d), want addr=%h (%0d,%0d)",
                            i, obs_addr[i], obs_base[i], obs_bnd[i], exp_addr[i], exp_base[i], exp_bnd[i]);
        end
      end
    end
    n_cmp++;
    if (stat_lines - l0 !== (STATS ? 32'd3 : 32'd0)) begin
      n_bad++; $display("FAIL multi_stat_lines: got delta %0d, want %0d", stat_lines - l0, STATS ? 3 : 0);
    end
  endtask

  task automatic test_zero_count();
    do_request(32'd77, 16'd0, 0, 0, 0, 1'b0);
    n_cmp++;
    if (obs_addr.size() != 0 || obs_base.size() != 0 || done_cnt != 1 || timed_out || done_after !== 1'b0) begin
      n_bad++; $display("FAIL zero_count: got %0d reads %0d windows done=%0d, want 0 0 1",
                        obs_addr.size(), obs_base.size(), done_cnt);
    end
  endtask

  task automatic test_stall();
    logic [31:0] s0;
    s0 = stat_stall;
    do_request(32'd17, 16'd5, 0, 0, 5, 1'b0);
    n_cmp++;
    if (stab_bad != 0 || obs_base.size() != 1 || obs_base[0] != 1 || obs_bnd[0] != 6 ||
        obs_data[0] !== line_data(32'h80)) begin
      n_bad++; $display("FAIL stall_hold: got %0d unstable cycles, %0d windows, want 0 and one (1,6)",
                        stab_bad, obs_base.size());
    end
    n_cmp++;
    if (stat_stall - s0 !== (STATS ? 32'd5 : 32'd0)) begin
      n_bad++; $display("FAIL stall_stat: got delta %0d, want %0d", stat_stall - s0, STATS ? 5 : 0);
    end
  endtask

  task automatic test_ar_backpressure();
    do_request(32'd40, 16'd3, 3, 0, 0, 1'b0);
    n_cmp++;
    if (stab_bad != 0 || obs_addr.size() != 1 || obs_addr[0] !== 32'h140 || done_cnt != 1) begin
      n_bad++; $display("FAIL ar_hold: got unstable=%0d reads=%0d, want 0 and one read at 0x140",
                        stab_bad, obs_addr.size());
    end
  endtask

  task automatic test_reset_in_wait();
    int bad;
    bad = 0;
    @(negedge clk);
    req_valid = 1'b1; req_start = 32'd0; req_count = 16'd4;
    @(negedge clk);
    req_valid = 1'b0; mem_arready = 1'b1;
    @(negedge clk);
    mem_arready = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = line_data(32'h0);
    @(negedge clk);
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (out_valid !== 1'b0 || req_ready !== 1'b1 || mem_arvalid !== 1'b0 || done !== 1'b0) bad++;
      @(negedge clk);
    end
    n_cmp++;
    if (bad != 0 || stat_lines !== 32'd0) begin
      n_bad++; $display("FAIL reset_in_wait: got %0d bad cycles lines=%0d, want idle and 0", bad, stat_lines);
    end
  endtask

  task automatic test_random();
    logic [31:0] s;
    logic [15:0] c;
    logic [31:0] l0;
    for (int k = 0; k < 30; k++) begin
      s = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 + 32'($urandom_range(0, 31))) : $urandom();
      c = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 40));
      l0 = stat_lines;
      build_model(s, c);
      do_request(s, c, $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 2), 1'b1);
      n_cmp++;
      if (obs_addr.size() != exp_addr.size() || obs_base.size() != exp_addr.size() ||
          done_cnt != 1 || timed_out || stab_bad != 0) begin
        n_bad++; $display("FAIL rand%0d_count: start=%h cnt=%0d got %0d reads %0d windows done=%0d, want %0d",
                          k, s, c, obs_addr.size(), obs_base.size(), done_cnt, exp_addr.size());
      end else begin
        for (int i = 0; i < exp_addr.size(); i++) begin
          n_cmp++;
          if (obs_addr[i] !== exp_addr[i] || obs_base[i] != exp_base[i] || obs_bnd[i] != exp_bnd[i] ||
              obs_data[i] !== line_data(exp_addr[i])) begin
            n_bad++; $display("FAIL rand%0d_line%0d: got addr=%h (%0d,%0d), want addr=%h (%0d,%0d)",
                              k, i, obs_addr[i], obs_base[i], obs_bnd[i], exp_addr[i], exp_base[i], exp_bnd[i]);
          end
        end
      end
      n_cmp++;
      if (stat_lines - l0 !== (STATS ? 32'(exp_addr.size()) : 32'd0)) begin
        n_bad++; $display("FAIL rand%0d_stat_lines: got delta %0d, want %0d",
                          k, stat_lines - l0, STATS ? exp_addr.size() : 0);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_start = 32'd0; req_count = 16'd0;
    mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; out_ready = 1'b0;
    test_reset();
    test_single_line();
    test_multi_line();
    test_zero_count();
    test_stall();
    test_ar_backpressure();
    test_reset_in_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
